// File: rtl/ebus_dev_port.sv
// ebus_dev_port: device-side EBUS transaction controller for one KL10 device.
// Decodes controller-select/function in IDLE, runs the demand/ack/xfer
// handshake, presents one driver slot to the EBUS mux and strobes/data to the
// device core. Bit vectors use KL10 numbering (bit 0 is the MSB).

typedef enum logic [2:0] {
   ebusfCONO     = 3'b000,
   ebusfCONI     = 3'b001,
   ebusfDATAO    = 3'b010,
   ebusfDATAI    = 3'b011,
   ebusfPIserved = 3'b100,
   ebusfPIaddrIn = 3'b101
} tEBUSfunction;

typedef struct packed {
   logic        driving;
   logic [0:35] data;
} tEBUSdriver;

module ebus_dev_port #(
   parameter logic [0:6]  DEV_CS        = 7'o000,
   parameter int unsigned DATAI_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic [0:6]   ebusCS,
   input  tEBUSfunction ebusFunc,
   input  logic         ebusDemand,
   input  logic         ebusReset,
   input  logic [0:35]  ebusDataIn,
   output logic         ebusAck,
   output logic         ebusXfer,
   output logic [0:7]   ebusPI,
   output tEBUSdriver   drv,
   output logic [0:35]  conoData,
   output logic [0:35]  dataoData,
   output logic         conoStb,
   output logic         dataoStb,
   input  logic [0:35]  coniData,
   input  logic [0:35]  dataiData,
   input  logic         dataiRdy,
   input  logic         piReq,
   input  logic [2:0]   piLevel,
   input  logic [0:35]  piVector,
   output logic         piServedStb,
   output logic         devReset
);

   localparam int unsigned CNT_W = $clog2(DATAI_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAITRDY = 2'd1,
      ST_XFER    = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic             ack_r, ack_s;
   logic             xfer_r, xfer_s;
   logic             driving_r, driving_s;
   logic [0:35]      drv_data_r, drv_data_s;
   logic [0:35]      cono_data_r, cono_data_s;
   logic [0:35]      datao_data_r, datao_data_s;
   logic             cono_stb_r, cono_stb_s;
   logic             datao_stb_r, datao_stb_s;
   logic             pi_served_stb_r, pi_served_stb_s;
   logic             dev_reset_r, dev_reset_s;
   logic [0:7]       pi_r, pi_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             cs_hit_s;
   logic             pi_hit_s;

   // Address matches; only consulted while IDLE.
   assign cs_hit_s = ebusDemand && (ebusCS == DEV_CS);
   assign pi_hit_s = ebusDemand && piReq && (piLevel != 3'd0) && (ebusCS[4:6] == piLevel);

   // Next-state and next-output logic for the handshake FSM.
   always_comb begin
      state_s         = state_r;
      ack_s           = ack_r;
      xfer_s          = xfer_r;
      driving_s       = driving_r;
      drv_data_s      = drv_data_r;
      cono_data_s     = cono_data_r;
      datao_data_s    = datao_data_r;
      cono_stb_s      = 1'b0;
      datao_stb_s     = 1'b0;
      pi_served_stb_s = 1'b0;
      cnt_s           = cnt_r;
      dev_reset_s     = ebusReset;
      if (ebusReset) begin
         // Soft reset beats everything, including a same-edge match.
         state_s   = ST_IDLE;
         ack_s     = 1'b0;
         xfer_s    = 1'b0;
         driving_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               case (ebusFunc)
                  ebusfCONO: begin
                     if (cs_hit_s) begin
                        cono_data_s = ebusDataIn;
                        cono_stb_s  = 1'b1;
                        ack_s       = 1'b1;
                        state_s     = ST_XFER;
                     end else begin
                        state_s = ST_IDLE;
                     end
                  end
                  ebusfDATAO: begin
                     if (cs_hit_s) begin
                        datao_data_s = ebusDataIn;
                        datao_stb_s  = 1'b1;
                        ack_s        = 1'b1;
                        state_s      = ST_XFER;
                     end else begin
                        state_s = ST_IDLE;
                     end
                  end
                  ebusfCONI: begin
                     if (cs_hit_s) begin
                        drv_data_s = coniData;
                        driving_s  = 1'b1;
                        ack_s      = 1'b1;
                        state_s    = ST_XFER;
                     end else begin
                        state_s = ST_IDLE;
                     end
                  end
                  ebusfDATAI: begin
                     if (cs_hit_s) begin
                        ack_s   = 1'b1;
                        cnt_s   = CNT_W'(DATAI_TIMEOUT);
                        state_s = ST_WAITRDY;
                     end else begin
                        state_s = ST_IDLE;
                     end
                  end
                  ebusfPIaddrIn: begin
                     if (pi_hit_s) begin
                        drv_data_s = piVector;
                        driving_s  = 1'b1;
                        ack_s      = 1'b1;
                        state_s    = ST_XFER;
                     end else begin
                        state_s = ST_IDLE;
                     end
                  end
                  ebusfPIserved: begin
                     if (pi_hit_s) begin
                        pi_served_stb_s = 1'b1;
                        ack_s           = 1'b1;
                        state_s         = ST_XFER;
                     end else begin
                        state_s = ST_IDLE;
                     end
                  end
                  default: state_s = ST_IDLE;
               endcase
            end
            ST_WAITRDY: begin
               if (!ebusDemand) begin
                  state_s   = ST_IDLE;
                  ack_s     = 1'b0;
                  xfer_s    = 1'b0;
                  driving_s = 1'b0;
               end else if (dataiRdy) begin
                  drv_data_s = dataiData;
                  driving_s  = 1'b1;
                  state_s    = ST_XFER;
               end else if (cnt_r <= CNT_W'(1)) begin
                  // Device never answered: keep ack so the EBOX times out cleanly.
                  state_s = ST_HOLD;
               end else begin
                  cnt_s = cnt_r - CNT_W'(1);
               end
            end
            ST_XFER: begin
               if (!ebusDemand) begin
                  state_s   = ST_IDLE;
                  ack_s     = 1'b0;
                  xfer_s    = 1'b0;
                  driving_s = 1'b0;
               end else begin
                  xfer_s = 1'b1;
               end
            end
            ST_HOLD: begin
               if (!ebusDemand) begin
                  state_s   = ST_IDLE;
                  ack_s     = 1'b0;
                  xfer_s    = 1'b0;
                  driving_s = 1'b0;
               end else begin
                  state_s = ST_HOLD;
               end
            end
            default: begin
               state_s   = ST_IDLE;
               ack_s     = 1'b0;
               xfer_s    = 1'b0;
               driving_s = 1'b0;
            end
         endcase
      end
   end

   // One-hot PI request by assigned level; level 0 means disabled.
   always_comb begin
      pi_s = 8'h00;
      if (piLevel != 3'd0) begin
         pi_s[piLevel] = piReq;
      end else begin
         pi_s = 8'h00;
      end
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_r         <= ST_IDLE;
         ack_r           <= 1'b0;
         xfer_r          <= 1'b0;
         driving_r       <= 1'b0;
         drv_data_r      <= 36'o0;
         cono_data_r     <= 36'o0;
         datao_data_r    <= 36'o0;
         cono_stb_r      <= 1'b0;
         datao_stb_r     <= 1'b0;
         pi_served_stb_r <= 1'b0;
         dev_reset_r     <= 1'b0;
         pi_r            <= 8'h00;
         cnt_r           <= '0;
      end else begin
         state_r         <= state_s;
         ack_r           <= ack_s;
         xfer_r          <= xfer_s;
         driving_r       <= driving_s;
         drv_data_r      <= drv_data_s;
         cono_data_r     <= cono_data_s;
         datao_data_r    <= datao_data_s;
         cono_stb_r      <= cono_stb_s;
         datao_stb_r     <= datao_stb_s;
         pi_served_stb_r <= pi_served_stb_s;
         dev_reset_r     <= dev_reset_s;
         pi_r            <= pi_s;
         cnt_r           <= cnt_s;
      end
   end

   assign ebusAck     = ack_r;
   assign ebusXfer    = xfer_r;
   assign ebusPI      = pi_r;
   assign drv.driving = driving_r;
   assign drv.data    = drv_data_r;
   assign conoData    = cono_data_r;
   assign dataoData   = datao_data_r;
   assign conoStb     = cono_stb_r;
   assign dataoStb    = datao_stb_r;
   assign piServedStb = pi_served_stb_r;
   assign devReset    = dev_reset_r;

endmodule

// File: doc/ebus_dev_port.md
# ebus_dev_port

Device-side EBUS transaction controller for one KL10 I/O device. It decodes controller-select and function from the EBOX and runs the demand/ack/xfer handshake for CONO, CONI, DATAO, DATAI and PI cycles. It presents one `tEBUSdriver` slot to the EBUS data mux and a simple strobe/data interface to the device core behind it.

## Interface

Parameters:
- `DEV_CS`, 7'o000: controller-select code this port answers to.
- `DATAI_TIMEOUT`, 64: max cycles to wait for `dataiRdy` before abandoning xfer.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rstN`  in  1  reset, asynchronous assert, active-low.
- `ebusCS`  in  7  EBUS.cs.
- `ebusFunc`  in  3  EBUS.func (`tEBUSfunction`).
- `ebusDemand`  in  1  EBUS.demand.
- `ebusReset`  in  1  EBUS.reset, synchronous soft reset.
- `ebusDataIn`  in  36  EBUS.data as seen by device (mux output).
- `ebusAck`  out  1  EBUS.ack contribution.
- `ebusXfer`  out  1  EBUS.xfer contribution.
- `ebusPI`  out  8  EBUS.pi contribution, one-hot by level.
- `drv`  out  `tEBUSdriver`  data/driving slot for the EBUS mux.
- `conoData`, `dataoData`  out  36  last CONO/DATAO word.
- `conoStb`, `dataoStb`  out  1  one-cycle write strobes.
- `coniData`  in  36  device status for CONI.
- `dataiData`  in  36  device data for DATAI.
- `dataiRdy`  in  1  `dataiData` valid.
- `piReq`  in  1  device interrupt request (level, held).
- `piLevel`  in  3  assigned PI level; 0 = disabled.
- `piVector`  in  36  word returned on PIaddrIn.
- `piServedStb`  out  1  one-cycle pulse on PIserved.
- `devReset`  out  1  one-cycle pulse on `ebusReset`.

## Operation

- States: IDLE, WAITRDY, XFER, HOLD.
- Match, evaluated in IDLE only:
  - CONO/CONI/DATAO/DATAI: `ebusDemand && ebusCS==DEV_CS`.
  - PIserved/PIaddrIn: `ebusDemand && piReq && piLevel!=0 && ebusCS[4:6]==piLevel`.
  - Func 3'b110 and 3'b111: never match.
- On match (edge E0):
  - CONO/DATAO: latch `ebusDataIn` into `conoData`/`dataoData`, go to XFER.
  - CONI: latch `coniData`, go to XFER.
  - PIaddrIn: latch `piVector`, go to XFER.
  - PIserved: no data, go to XFER.
  - DATAI: go to WAITRDY, load timeout counter.
- WAITRDY:
  - On an edge with `dataiRdy` high, latch `dataiData` and go to XFER.
  - Counter decrements each cycle. At 0, go to HOLD with no xfer and no drive.
- XFER/HOLD: stay while `ebusDemand` high. On the edge where `ebusDemand` is sampled low, go to IDLE.
- A new transaction requires passing through IDLE, so demand must drop between cycles.
- `ebusPI[piLevel]` = `piReq`, for `piLevel` 1..7. Other bits are 0. `piLevel`=0 drives all zero. Registered, one-cycle lag.
- `ebusReset` sampled high, from any state: go to IDLE, clear all handshake outputs, pulse `devReset` next cycle. Latched data regs are kept.

## Timing

- Reset values (`rstN` low): state IDLE; `ebusAck`, `ebusXfer`, `drv.driving`, all strobes, `devReset` = 0; `ebusPI` = 0; `drv.data`, `conoData`, `dataoData` = 0.
- All outputs are registered.
- Non-DATAI, match at edge E0:
  - `ebusAck`=1 from E0+1.
  - Strobe (`conoStb`/`dataoStb`/`piServedStb`) high exactly during E0..E1.
  - Read funcs: `drv.driving`=1 from E0+1.
  - `ebusXfer`=1 from E1+1.
- DATAI:
  - `ebusAck`=1 from E0+1.
  - `dataiRdy` seen at edge Er: `drv.driving`=1 from Er+1, `ebusXfer`=1 from Er+2.
- Release: demand sampled low at edge Ed → `ebusAck`, `ebusXfer`, `drv.driving` all 0 from Ed+1.
- Demand dropped before xfer is a valid abort: release as above, no further strobes.
- `ebusReset` and match on the same edge: reset wins, no ack.
- Timeout: `dataiRdy` absent for `DATAI_TIMEOUT` edges after E0 → HOLD; `ebusAck` stays 1, xfer never asserts.

## Test plan

- CONO, DEV_CS=7'o014, data 36'o123456_701234, demand held 6 cycles:
  - ack at E0+1, `conoStb` one cycle, `conoData` = 36'o123456_701234, xfer at E0+2.
  - All drop one cycle after demand low.
- CONI, `coniData`=36'o777000_000777:
  - `drv.data` matches, `drv.driving`=1 from E0+1, xfer from E0+2.
  - CS=7'o015 produces no ack.
- DATAI, `dataiRdy` raised 5 cycles after E0:
  - xfer exactly 2 cycles after rdy sampled.
  - Second run, rdy never raised, TIMEOUT=8: ack stays 1, no xfer, IDLE after demand drop.
- PI, `piLevel`=5, `piReq`=1:
  - `ebusPI`=8'b0000_0100.
  - PIaddrIn with cs[4:6]=5 drives `piVector`; PIserved pulses `piServedStb`.
  - cs[4:6]=4 gets no response.
- Mid-transaction `ebusReset` during DATAO XFER:
  - outputs 0 next cycle, `devReset` one-cycle pulse.
  - `rstN` low mid-DATAI clears everything asynchronously.
- Back-to-back: demand held high across two transactions yields only one ack. Demand low one cycle, then high again, starts a new transaction.
